// File: rtl/decode_cycle_if.sv
// rtl/decode_cycle_if.sv - IF/ID, writeback and ID/EX signal bundle for the decode stage
interface decode_cycle_if;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        FlushE;
    logic        RegWriteW;
    logic [4:0]  RDW;
    logic [31:0] ResultW;

    logic        RegWriteE;
    logic        MemWriteE;
    logic        BranchE;
    logic        JumpE;
    logic        ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E;
    logic [31:0] RD2E;
    logic [31:0] Imm_Ext_E;
    logic [4:0]  RS1_E;
    logic [4:0]  RS2_E;
    logic [4:0]  RD_E;
    logic [31:0] PCE;
    logic [31:0] PCPlus4E;

    // Pipeline side that drives the decode stage (fetch, writeback, hazard unit)
    modport master (
        output InstrD, PCD, PCPlus4D, FlushE, RegWriteW, RDW, ResultW,
        input  RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE, ResultSrcE, ALUControlE,
        input  RD1E, RD2E, Imm_Ext_E, RS1_E, RS2_E, RD_E, PCE, PCPlus4E
    );

    // Decode stage itself
    modport slave (
        input  InstrD, PCD, PCPlus4D, FlushE, RegWriteW, RDW, ResultW,
        output RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE, ResultSrcE, ALUControlE,
        output RD1E, RD2E, Imm_Ext_E, RS1_E, RS2_E, RD_E, PCE, PCPlus4E
    );
endinterface

// File: rtl/decode_cycle.sv
// rtl/decode_cycle.sv - RV32I decode stage: control decode, register file, immediates, ID/EX register
module decode_cycle (
    input  logic          clk,
    input  logic          rst,
    decode_cycle_if.slave bus
);
    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        alu_src;
        logic [1:0]  result_src;
        logic [2:0]  alu_ctrl;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
    } idex_t;

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rs1_idx;
    logic [4:0]  rs2_idx;
    logic [4:0]  rd_idx;
    logic [31:0] imm_i, imm_s, imm_b, imm_j;

    assign instr   = bus.InstrD;
    assign opcode  = instr[6:0];
    assign funct3  = instr[14:12];
    assign rs1_idx = instr[19:15];
    assign rs2_idx = instr[24:20];
    assign rd_idx  = instr[11:7];
    assign imm_i   = {{20{instr[31]}}, instr[31:20]};
    assign imm_s   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b   = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_j   = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];
    logic        wb_en;

    // x0 is never written, so it stays at its reset value of zero
    assign wb_en = bus.RegWriteW && (bus.RDW != 5'd0);

    // Register-file next state: single write port from writeback
    always_comb begin
        regs_d = regs_q;
        if (wb_en) begin
            regs_d[bus.RDW] = bus.ResultW;
        end
    end

    // Register-file storage, cleared by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    logic [31:0] rd1, rd2;

    // Reads are write-first: a same-cycle writeback to the read index is forwarded
    always_comb begin
        rd1 = regs_q[rs1_idx];
        rd2 = regs_q[rs2_idx];
        if (wb_en && (bus.RDW == rs1_idx)) rd1 = bus.ResultW;
        if (wb_en && (bus.RDW == rs2_idx)) rd2 = bus.ResultW;
        if (rs1_idx == 5'd0) rd1 = 32'd0;
        if (rs2_idx == 5'd0) rd2 = 32'd0;
    end

    logic        reg_write, mem_write, branch, jump, alu_src;
    logic [1:0]  result_src;
    logic [2:0]  alu_ctrl;
    logic [31:0] imm;

    // Main/ALU decoder; anything unrecognised leaves every control at zero (bubble)
    always_comb begin
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        alu_src    = 1'b0;
        result_src = 2'b00;
        alu_ctrl   = 3'b000;
        imm        = 32'd0;
        case (opcode)
            7'b0000011: begin
                reg_write  = 1'b1;
                alu_src    = 1'b1;
                result_src = 2'b01;
                imm        = imm_i;
            end
            7'b0100011: begin
                mem_write = 1'b1;
                alu_src   = 1'b1;
                imm       = imm_s;
            end
            7'b0110011: begin
                case (funct3)
                    3'b000: begin reg_write = 1'b1; alu_ctrl = instr[30] ? 3'b001 : 3'b000; end
                    3'b010: begin reg_write = 1'b1; alu_ctrl = 3'b101; end
                    3'b110: begin reg_write = 1'b1; alu_ctrl = 3'b011; end
                    3'b111: begin reg_write = 1'b1; alu_ctrl = 3'b010; end
                    default: ;
                endcase
            end
            7'b0010011: begin
                imm = imm_i;
                case (funct3)
                    3'b000: begin reg_write = 1'b1; alu_src = 1'b1; alu_ctrl = 3'b000; end
                    3'b010: begin reg_write = 1'b1; alu_src = 1'b1; alu_ctrl = 3'b101; end
                    3'b110: begin reg_write = 1'b1; alu_src = 1'b1; alu_ctrl = 3'b011; end
                    3'b111: begin reg_write = 1'b1; alu_src = 1'b1; alu_ctrl = 3'b010; end
                    default: ;
                endcase
            end
            7'b1100011: begin
                branch   = 1'b1;
                alu_ctrl = 3'b001;
                imm      = imm_b;
            end
            7'b1101111: begin
                reg_write  = 1'b1;
                jump       = 1'b1;
                result_src = 2'b10;
                imm        = imm_j;
            end
            default: ;
        endcase
    end

    idex_t idex_d, idex_q;

    // ID/EX next value; a taken branch/jump in EX squashes the whole register
    always_comb begin
        idex_d = '0;
        if (!bus.FlushE) begin
            idex_d.reg_write  = reg_write;
            idex_d.mem_write  = mem_write;
            idex_d.branch     = branch;
            idex_d.jump       = jump;
            idex_d.alu_src    = alu_src;
            idex_d.result_src = result_src;
            idex_d.alu_ctrl   = alu_ctrl;
            idex_d.rd1        = rd1;
            idex_d.rd2        = rd2;
            idex_d.imm        = imm;
            idex_d.rs1        = rs1_idx;
            idex_d.rs2        = rs2_idx;
            idex_d.rd         = rd_idx;
            idex_d.pc         = bus.PCD;
            idex_d.pc_plus4   = bus.PCPlus4D;
        end
    end

    // ID/EX pipeline register, advances every edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign bus.RegWriteE   = idex_q.reg_write;
    assign bus.MemWriteE   = idex_q.mem_write;
    assign bus.BranchE     = idex_q.branch;
    assign bus.JumpE       = idex_q.jump;
    assign bus.ALUSrcE     = idex_q.alu_src;
    assign bus.ResultSrcE  = idex_q.result_src;
    assign bus.ALUControlE = idex_q.alu_ctrl;
    assign bus.RD1E        = idex_q.rd1;
    assign bus.RD2E        = idex_q.rd2;
    assign bus.Imm_Ext_E   = idex_q.imm;
    assign bus.RS1_E       = idex_q.rs1;
    assign bus.RS2_E       = idex_q.rs2;
    assign bus.RD_E        = idex_q.rd;
    assign bus.PCE         = idex_q.pc;
    assign bus.PCPlus4E    = idex_q.pc_plus4;
endmodule

// File: tb/tb_decode_cycle.sv
// tb/tb_decode_cycle.sv - directed self-checking bench for decode_cycle
module tb_decode_cycle;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    decode_cycle_if bus ();

    decode_cycle dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [9:0]   ctrl_e;
    logic [184:0] all_e;
    assign ctrl_e = {bus.RegWriteE, bus.MemWriteE, bus.BranchE, bus.JumpE, bus.ALUSrcE,
                     bus.ResultSrcE, bus.ALUControlE};
    assign all_e  = {ctrl_e, bus.RD1E, bus.RD2E, bus.Imm_Ext_E, bus.RS1_E, bus.RS2_E, bus.RD_E,
                     bus.PCE, bus.PCPlus4E};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic flush,
                         input logic we, input logic [4:0] rdw, input logic [31:0] res);
        bus.InstrD    = instr;
        bus.PCD       = pc;
        bus.PCPlus4D  = pc + 32'd4;
        bus.FlushE    = flush;
        bus.RegWriteW = we;
        bus.RDW       = rdw;
        bus.ResultW   = res;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive($urandom, $urandom, 1'b0, 1'b1, 5'($urandom_range(1, 31)), $urandom);
            tick();
            total++;
            if (all_e !== '0) begin
                bad++;
                $display("FAIL reset_hold iter=%0d got=%h want=0", k, all_e);
            end
        end
        rst = 1'b1;
        drive(32'h006282B3, 32'h100, 1'b0, 1'b0, 5'd0, 32'd0);
        tick();
        total++;
        if (bus.PCE !== 32'h100) begin
            bad++;
            $display("FAIL first_edge_after_release got=%h want=00000100", bus.PCE);
        end
        #2 rst = 1'b0;
        #1;
        total++;
        if (all_e !== '0) begin
            bad++;
            $display("FAIL async_reset got=%h want=0", all_e);
        end
        rst = 1'b1;
        for (int i = 1; i < 32; i++) begin
            logic [4:0] r;
            r = 5'(i);
            drive({7'd0, r, r, 3'b000, 5'd0, 7'b0110011}, 32'h0, 1'b0, 1'b0, 5'd0, 32'd0);
            tick();
            total++;
            if ({bus.RD1E, bus.RD2E} !== 64'd0) begin
                bad++;
                $display("FAIL reg_after_reset x%0d got=%h_%h want=0", i, bus.RD1E, bus.RD2E);
            end
        end
    endtask

    task automatic test_add();
        drive(32'h0, 32'h0, 1'b0, 1'b1, 5'd5, 32'h10);
        tick();
        drive(32'h0, 32'h0, 1'b0, 1'b1, 5'd6, 32'h3);
        tick();
        drive(32'h006282B3, 32'h200, 1'b0, 1'b0, 5'd0, 32'd0);
        tick();
        total++;
        if ({bus.RD1E, bus.RD2E} !== {32'h10, 32'h3}) begin
            bad++;
            $display("FAIL add_operands got=%h_%h want=00000010_00000003", bus.RD1E, bus.RD2E);
        end
        total++;
        if (ctrl_e !== 10'b1000000000) begin
            bad++;
            $display("FAIL add_ctrl got=%b want=1000000000", ctrl_e);
        end
        total++;
        if ({bus.RS1_E, bus.RS2_E, bus.RD_E, bus.Imm_Ext_E} !== {5'd5, 5'd6, 5'd5, 32'd0}) begin
            bad++;
            $display("FAIL add_fields got=%0d,%0d,%0d imm=%h want=5,6,5 imm=0",
                     bus.RS1_E, bus.RS2_E, bus.RD_E, bus.Imm_Ext_E);
        end
        total++;
        if ({bus.PCE, bus.PCPlus4E} !== {32'h200, 32'h204}) begin
            bad++;
            $display("FAIL add_pc got=%h_%h want=00000200_00000204", bus.PCE, bus.PCPlus4E);
        end
        drive(32'h406282B3, 32'h204, 1'b0, 1'b0, 5'd0, 32'd0);
        tick();
        total++;
        if (ctrl_e !== 10'b1000000001) begin
            bad++;
            $display("FAIL sub_ctrl got=%b want=1000000001", ctrl_e);
        end
    endtask

    task automatic test_bypass();
        drive(32'h00038433, 32'h0, 1'b0, 1'b1, 5'd7, 32'hDEADBEEF);
        tick();
        total++;
        if ({bus.RD1E, bus.RD2E} !== {32'hDEADBEEF, 32'h0}) begin
            bad++;
            $display("FAIL bypass_x7 got=%h_%h want=deadbeef_00000000", bus.RD1E, bus.RD2E);
        end
        drive(32'h00038433, 32'h0, 1'b0, 1'b0, 5'd0, 32'd0);
        tick();
        total++;
        if (bus.RD1E !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL x7_committed got=%h want=deadbeef", bus.RD1E);
        end
        drive(32'h000000B3, 32'h0, 1'b0, 1'b1, 5'd0, 32'h1234);
        tick();
        total++;
        if ({bus.RD1E, bus.RD2E} !== 64'd0) begin
            bad++;
            $display("FAIL x0_bypass got=%h_%h want=0", bus.RD1E, bus.RD2E);
        end
        drive(32'h000000B3, 32'h0, 1'b0, 1'b0, 5'd0, 32'd0);
        tick();
        total++;
        if ({bus.RD1E, bus.RD2E} !== 64'd0) begin
            bad++;
            $display("FAIL x0_stored got=%h_%h want=0", bus.RD1E, bus.RD2E);
        end
    endtask

    task automatic test_imm();
        logic [31:0] instrs [6];
        logic [31:0] imms   [6];
        logic [9:0]  ctrls  [6];
        instrs[0] = 32'hFFC12083; imms[0] = 32'hFFFFFFFC; ctrls[0] = 10'b1000101000;
        instrs[1] = 32'hFE112E23; imms[1] = 32'hFFFFFFFC; ctrls[1] = 10'b0100100000;
        instrs[2] = 32'hFE000CE3; imms[2] = 32'hFFFFFFF8; ctrls[2] = 10'b0010000001;
        instrs[3] = 32'h001000EF; imms[3] = 32'h00000800; ctrls[3] = 10'b1001010000;
        instrs[4] = 32'h40028193; imms[4] = 32'h00000400; ctrls[4] = 10'b1000100000;
        instrs[5] = 32'h0012A193; imms[5] = 32'h00000001; ctrls[5] = 10'b1000100101;
        for (int i = 0; i < 6; i++) begin
            drive(instrs[i], 32'h1000 + 32'(i * 4), 1'b0, 1'b0, 5'd0, 32'd0);
            tick();
            total++;
            if (bus.Imm_Ext_E !== imms[i]) begin
                bad++;
                $display("FAIL imm[%0d] got=%h want=%h", i, bus.Imm_Ext_E, imms[i]);
            end
            total++;
            if (ctrl_e !== ctrls[i]) begin
                bad++;
                $display("FAIL ctrl[%0d] got=%b want=%b", i, ctrl_e, ctrls[i]);
            end
        end
    endtask

    task automatic test_flush();
        drive(32'h006282B3, 32'h300, 1'b1, 1'b1, 5'd9, 32'hCAFEF00D);
        tick();
        total++;
        if (all_e !== '0) begin
            bad++;
            $display("FAIL flush_clear got=%h want=0", all_e);
        end
        drive(32'h00048033, 32'h304, 1'b0, 1'b0, 5'd0, 32'd0);
        tick();
        total++;
        if (bus.RD1E !== 32'hCAFEF00D) begin
            bad++;
            $display("FAIL flush_write_commit got=%h want=cafef00d", bus.RD1E);
        end
    endtask

    task automatic test_illegal();
        drive(32'h0000007F, 32'h400, 1'b0, 1'b0, 5'd0, 32'd0);
        tick();
        total++;
        if ({ctrl_e, bus.Imm_Ext_E, bus.PCE} !== {10'd0, 32'd0, 32'h400}) begin
            bad++;
            $display("FAIL illegal_opcode ctrl=%b imm=%h pc=%h want ctrl=0 imm=0 pc=00000400",
                     ctrl_e, bus.Imm_Ext_E, bus.PCE);
        end
        drive(32'h006290B3, 32'h404, 1'b0, 1'b0, 5'd0, 32'd0);
        tick();
        total++;
        if ({ctrl_e, bus.PCE, bus.RD1E, bus.RD_E} !== {10'd0, 32'h404, 32'h10, 5'd1}) begin
            bad++;
            $display("FAIL rtype_f3_001 ctrl=%b pc=%h rd1=%h rd=%0d want ctrl=0 pc=00000404 rd1=00000010 rd=1",
                     ctrl_e, bus.PCE, bus.RD1E, bus.RD_E);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        drive(32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
        test_reset();
        test_add();
        test_bypass();
        test_imm();
        test_flush();
        test_illegal();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
